// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FIFO slice.
//   FIFO_STD / FIFO_FWFT : read-mode selector values for the FWFT parameter
//   ptrWidth()           : pointer width, one bit wider than the address so
//                          that full and empty stay distinguishable
//   isPow2()             : used by the elaboration-time parameter checks
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptrWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit isPow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// fifo_ram_sdp
// Simple dual-port storage array: one write port, one read port, single clock.
// REG_READ=1 gives a registered read (block-RAM style) with a clearable output
// register; REG_READ=0 gives an asynchronous read (distributed-RAM style).
// The array itself has no reset so it stays inferable as a RAM.
// Ports:
//   i_clk     clock, rising edge
//   i_wrEn    write strobe
//   i_wrAddr  write address
//   i_wrData  write data
//   i_rdEn    read strobe (registered mode only)
//   i_rdClr   synchronous clear of the read register (registered mode only)
//   i_rdAddr  read address
//   o_rdData  read data
module fifo_ram_sdp #(
  parameter int DATA_W   = 18,
  parameter int ADDR_W   = 10,
  parameter bit REG_READ = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_wrEn,
  input  logic [ADDR_W-1:0] i_wrAddr,
  input  logic [DATA_W-1:0] i_wrData,
  input  logic              i_rdEn,
  input  logic              i_rdClr,
  input  logic [ADDR_W-1:0] i_rdAddr,
  output logic [DATA_W-1:0] o_rdData
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // Write port; deliberately reset-free so contents survive a FIFO reset.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  generate
    if (REG_READ) begin : g_regRead
      logic [DATA_W-1:0] r_rdData;

      // Output register only loads on a read and holds otherwise; the clear
      // wins over a read in the same cycle.
      always_ff @(posedge i_clk) begin
        if (i_rdClr) begin
          r_rdData <= '0;
        end else if (i_rdEn) begin
          r_rdData <= r_mem[i_rdAddr];
        end
      end

      assign o_rdData = r_rdData;
    end else begin : g_asyncRead
      // Read strobe and clear have no meaning for a combinational read.
      logic w_unusedRdCtrl;
      assign w_unusedRdCtrl = i_rdEn ^ i_rdClr;

      assign o_rdData = r_mem[i_rdAddr];
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
// Single-clock parameterised FIFO with standard (registered) or
// first-word-fall-through read, threshold flags and sticky error flags.
// Ports:
//   clk_100MHz    clock, rising edge
//   reset_rtl_0   synchronous active-low reset
//   wr_en, din    write request and data
//   full          count == DEPTH
//   almost_full   count >= AF_THRESH
//   rd_en         read request (FWFT: pop of the current head)
//   dout, valid   read data and its qualifier
//   empty         count == 0
//   almost_empty  count <= AE_THRESH
//   count         number of stored words
//   err_clr       clears overflow/underflow
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = 18,
  parameter int DEPTH     = 1024,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4
) (
  input  logic                   clk_100MHz,
  input  logic                   reset_rtl_0,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      din,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      dout,
  output logic                   valid,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W  = ptrWidth(DEPTH);
  localparam int ADDR_W = PTR_W - 1;

  localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] C_AF    = PTR_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] C_AE    = PTR_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);

  // Reject illegal parameter sets at elaboration.
  generate
    if (!isPow2(DEPTH) || (DEPTH < 4)) begin : g_badDepth
      $error("fifo_sync_param: DEPTH must be a power of two and at least 4");
    end
    if (!((AE_THRESH > 0) && (AE_THRESH < AF_THRESH) && (AF_THRESH < DEPTH))) begin : g_badThresh
      $error("fifo_sync_param: thresholds must satisfy 0 < AE_THRESH < AF_THRESH < DEPTH");
    end
    if ((FWFT != FIFO_STD) && (FWFT != FIFO_FWFT)) begin : g_badMode
      $error("fifo_sync_param: FWFT must be 0 or 1");
    end
  endgenerate

  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic              r_overflow;
  logic              r_underflow;
  logic [PTR_W-1:0]  w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_wrAcc;
  logic              w_rdAcc;
  logic              w_rdClr;
  logic [DATA_W-1:0] w_ramDout;

  // The extra pointer MSB makes the plain difference a true occupancy count
  // from 0 to DEPTH, so every flag is a simple decode of registered state.
  assign w_count = r_wrPtr - r_rdPtr;
  assign w_full  = (w_count == C_DEPTH);
  assign w_empty = (w_count == '0);

  // Acceptance looks only at current state, so a write while full is refused
  // even if a read frees a slot on the same edge.
  assign w_wrAcc = wr_en & ~w_full;
  assign w_rdAcc = rd_en & ~w_empty;
  assign w_rdClr = ~reset_rtl_0;

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= C_AF);
  assign almost_empty = (w_count <= C_AE);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // Pointer update; reset rewinds both pointers, discarding stored words
  // without touching the array.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_rtl_0) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + C_ONE;
      end
      if (w_rdAcc) begin
        r_rdPtr <= r_rdPtr + C_ONE;
      end
    end
  end

  // Sticky error flags; a fresh error in the clearing cycle wins over the clear.
  always_ff @(posedge clk_100MHz) begin
    if (!reset_rtl_0) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end else if (err_clr) begin
        r_overflow <= 1'b0;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end else if (err_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

  fifo_ram_sdp #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .REG_READ (FWFT == FIFO_STD)
  ) u_ram (
    .i_clk    (clk_100MHz),
    .i_wrEn   (w_wrAcc),
    .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
    .i_wrData (din),
    .i_rdEn   (w_rdAcc),
    .i_rdClr  (w_rdClr),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_ramDout)
  );

  generate
    if (FWFT == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; it is forced to zero while empty so
      // that stale array contents never appear after reset.
      assign dout  = w_empty ? '0 : w_ramDout;
      assign valid = ~w_empty;
    end else begin : g_std
      logic r_valid;

      // valid marks only the cycle right after an accepted read.
      always_ff @(posedge clk_100MHz) begin
        if (!reset_rtl_0) begin
          r_valid <= 1'b0;
        end else begin
          r_valid <= w_rdAcc;
        end
      end

      assign dout  = w_ramDout;
      assign valid = r_valid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param
// Directed and scoreboard checks of fifo_sync_param with DEPTH=16,
// AF_THRESH=12, AE_THRESH=4; one instance in standard read mode and one in
// first-word-fall-through mode.
module tb_fifo_sync_param;

  localparam int DATA_W = 18;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance signals
  logic              sRst = 1'b0;
  logic              sWr = 1'b0;
  logic              sRd = 1'b0;
  logic              sClr = 1'b0;
  logic [DATA_W-1:0] sDin = '0;
  logic [DATA_W-1:0] sDout;
  logic              sFull, sAfull, sEmpty, sAempty, sValid, sOvf, sUnf;
  logic [CNT_W-1:0]  sCount;

  // FWFT-mode instance signals
  logic              fRst = 1'b0;
  logic              fWr = 1'b0;
  logic              fRd = 1'b0;
  logic              fClr = 1'b0;
  logic [DATA_W-1:0] fDin = '0;
  logic [DATA_W-1:0] fDout;
  logic              fFull, fAfull, fEmpty, fAempty, fValid, fOvf, fUnf;
  logic [CNT_W-1:0]  fCount;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] q[$];

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(0), .AF_THRESH(12), .AE_THRESH(4)
  ) dutStd (
    .clk_100MHz(clk), .reset_rtl_0(sRst), .wr_en(sWr), .din(sDin),
    .full(sFull), .almost_full(sAfull), .rd_en(sRd), .dout(sDout),
    .valid(sValid), .empty(sEmpty), .almost_empty(sAempty), .count(sCount),
    .err_clr(sClr), .overflow(sOvf), .underflow(sUnf)
  );

  fifo_sync_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .FWFT(1), .AF_THRESH(12), .AE_THRESH(4)
  ) dutFwft (
    .clk_100MHz(clk), .reset_rtl_0(fRst), .wr_en(fWr), .din(fDin),
    .full(fFull), .almost_full(fAfull), .rd_en(fRd), .dout(fDout),
    .valid(fValid), .empty(fEmpty), .almost_empty(fAempty), .count(fCount),
    .err_clr(fClr), .overflow(fOvf), .underflow(fUnf)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advances one clock edge and settles just after it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset both instances and check reset state
    applyStimulus();
    applyStimulus();
    checkOutput("std.rst.count",  32'(sCount),  32'd0);
    checkOutput("std.rst.empty",  32'(sEmpty),  32'd1);
    checkOutput("std.rst.aempty", 32'(sAempty), 32'd1);
    checkOutput("std.rst.full",   32'(sFull),   32'd0);
    checkOutput("std.rst.afull",  32'(sAfull),  32'd0);
    checkOutput("std.rst.valid",  32'(sValid),  32'd0);
    checkOutput("std.rst.dout",   32'(sDout),   32'd0);
    checkOutput("std.rst.ovf",    32'(sOvf),    32'd0);
    checkOutput("std.rst.unf",    32'(sUnf),    32'd0);
    checkOutput("fw.rst.valid",   32'(fValid),  32'd0);
    checkOutput("fw.rst.empty",   32'(fEmpty),  32'd1);
    checkOutput("fw.rst.dout",    32'(fDout),   32'd0);
    sRst = 1'b1;
    fRst = 1'b1;

    // Fill the standard instance 0x00001..0x00010 on the first edge out of reset
    sWr = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sDin = 18'(i);
      applyStimulus();
      checkOutput($sformatf("fill%0d.count", i),  32'(sCount),  32'(i));
      checkOutput($sformatf("fill%0d.afull", i),  32'(sAfull),  32'(i >= 12));
      checkOutput($sformatf("fill%0d.full", i),   32'(sFull),   32'(i == 16));
      checkOutput($sformatf("fill%0d.aempty", i), 32'(sAempty), 32'(i <= 4));
    end
    sDin = 18'h3FFFF;
    applyStimulus();
    checkOutput("over.ovf",   32'(sOvf),   32'd1);
    checkOutput("over.count", 32'(sCount), 32'd16);
    sWr  = 1'b0;
    sClr = 1'b1;
    applyStimulus();
    checkOutput("clr.ovf", 32'(sOvf), 32'd0);
    sClr = 1'b0;

    // Drain with 17 reads
    sRd = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus();
      checkOutput($sformatf("drain%0d.valid", i), 32'(sValid), 32'd1);
      checkOutput($sformatf("drain%0d.dout", i),  32'(sDout),  32'(i));
      checkOutput($sformatf("drain%0d.count", i), 32'(sCount), 32'(16 - i));
    end
    applyStimulus();
    checkOutput("under.valid", 32'(sValid), 32'd0);
    checkOutput("under.dout",  32'(sDout),  32'h10);
    checkOutput("under.unf",   32'(sUnf),   32'd1);
    checkOutput("under.empty", 32'(sEmpty), 32'd1);
    sRd = 1'b0;
    applyStimulus();
    checkOutput("hold.valid", 32'(sValid), 32'd0);
    checkOutput("hold.dout",  32'(sDout),  32'h10);
    // A new underflow in the clearing cycle beats the clear
    sRd  = 1'b1;
    sClr = 1'b1;
    applyStimulus();
    checkOutput("setclr.unf", 32'(sUnf), 32'd1);
    sRd = 1'b0;
    applyStimulus();
    checkOutput("clr.unf", 32'(sUnf), 32'd0);
    sClr = 1'b0;

    // Refill across the pointer wrap, then simultaneous write/read at full
    sWr = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sDin = 18'(32'h100 + i);
      applyStimulus();
    end
    checkOutput("refill.full", 32'(sFull), 32'd1);
    sDin = 18'h3FFFF;
    sRd  = 1'b1;
    applyStimulus();
    checkOutput("simfull.count", 32'(sCount), 32'd15);
    checkOutput("simfull.ovf",   32'(sOvf),   32'd1);
    checkOutput("simfull.dout",  32'(sDout),  32'h101);
    sWr = 1'b0;
    for (int i = 2; i <= 8; i++) begin
      applyStimulus();
      checkOutput($sformatf("part%0d.dout", i), 32'(sDout), 32'(32'h100 + i));
    end
    checkOutput("part.count", 32'(sCount), 32'd8);
    sWr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sDin = 18'(32'h200 + k);
      applyStimulus();
      checkOutput($sformatf("sim8_%0d.count", k), 32'(sCount), 32'd8);
      checkOutput($sformatf("sim8_%0d.dout", k),  32'(sDout),  32'(32'h109 + k));
    end
    sRd  = 1'b0;
    sDin = 18'h300;
    applyStimulus();
    checkOutput("pre_rst.count", 32'(sCount), 32'd9);

    // Reset mid-run with all requests active
    sRst = 1'b0;
    sRd  = 1'b1;
    sClr = 1'b1;
    applyStimulus();
    checkOutput("midrst.count", 32'(sCount), 32'd0);
    checkOutput("midrst.empty", 32'(sEmpty), 32'd1);
    checkOutput("midrst.ovf",   32'(sOvf),   32'd0);
    checkOutput("midrst.unf",   32'(sUnf),   32'd0);
    checkOutput("midrst.valid", 32'(sValid), 32'd0);
    checkOutput("midrst.dout",  32'(sDout),  32'd0);
    sRst = 1'b1;
    sClr = 1'b0;
    sRd  = 1'b0;
    sDin = 18'h12345;
    applyStimulus();
    checkOutput("postrst.count", 32'(sCount), 32'd1);
    sWr = 1'b0;
    sRd = 1'b1;
    applyStimulus();
    checkOutput("postrst.dout",  32'(sDout),  32'h12345);
    checkOutput("postrst.valid", 32'(sValid), 32'd1);
    sRd = 1'b0;

    // FWFT: word written into empty appears one edge later
    fWr  = 1'b1;
    fDin = 18'h2AAAA;
    checkOutput("fw.prewr.valid", 32'(fValid), 32'd0);
    applyStimulus();
    checkOutput("fw.wr.valid", 32'(fValid), 32'd1);
    checkOutput("fw.wr.dout",  32'(fDout),  32'h2AAAA);
    checkOutput("fw.wr.count", 32'(fCount), 32'd1);
    fWr = 1'b0;
    fRd = 1'b1;
    applyStimulus();
    checkOutput("fw.pop.empty", 32'(fEmpty), 32'd1);
    checkOutput("fw.pop.valid", 32'(fValid), 32'd0);
    fRd = 1'b0;
    fWr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      fDin = 18'(32'h11 * i);
      applyStimulus();
    end
    fWr = 1'b0;
    fRd = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      checkOutput($sformatf("fw.head%0d", i), 32'(fDout), 32'(32'h11 * i));
      applyStimulus();
    end
    applyStimulus();
    checkOutput("fw.under.unf", 32'(fUnf), 32'd1);
    fRd = 1'b0;

    // Random traffic on both instances against one scoreboard queue
    q.delete();
    for (int c = 0; c < 5000; c++) begin
      logic              wr, rd, wrAcc, rdAcc;
      logic [DATA_W-1:0] din, expHead;
      if (((c / 250) % 2) == 0) begin
        wr = ($urandom_range(0, 3) != 0);
        rd = ($urandom_range(0, 3) == 0);
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        rd = ($urandom_range(0, 3) != 0);
      end
      din   = 18'($urandom);
      sWr = wr; fWr = wr; sRd = rd; fRd = rd; sDin = din; fDin = din;
      wrAcc   = wr && (q.size() < DEPTH);
      rdAcc   = rd && (q.size() > 0);
      expHead = '0;
      if (rdAcc) expHead = q.pop_front();
      if (wrAcc) q.push_back(din);
      applyStimulus();
      checkOutput("rnd.std.count", 32'(sCount), 32'(q.size()));
      checkOutput("rnd.fw.count",  32'(fCount), 32'(q.size()));
      checkOutput("rnd.std.valid", 32'(sValid), 32'(rdAcc));
      if (rdAcc) checkOutput("rnd.std.dout", 32'(sDout), 32'(expHead));
      checkOutput("rnd.fw.valid", 32'(fValid), 32'(q.size() > 0));
      if (q.size() > 0) checkOutput("rnd.fw.dout", 32'(fDout), 32'(q[0]));
    end
    sWr = 1'b0; fWr = 1'b0; sRd = 1'b0; fRd = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
